// File: rtl/cb_config_loader_if.sv
// Host-side configuration stream and readback bus
// for the connection block configuration loader.
interface cb_config_loader_if #(
    parameter int DW = 16
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_data;
    logic          rb_valid;
    logic [DW-1:0] rb_data;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready,
        input  rb_valid,
        input  rb_data
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready,
        output rb_valid,
        output rb_data
    );
endinterface

// File: rtl/cb_config_loader.sv
// Serialises host words LSB-first into a connection block
// config chain, issues the set strobe and returns readback.
module cb_config_loader #(
    parameter int DW        = 16,
    parameter int CHAIN_LEN = 40,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    cb_config_loader_if.slave bus,
    input  logic              start,
    input  logic              abort,
    output logic              cen,
    output logic              set_in,
    output logic              shift_in,
    input  logic              shift_out,
    output logic              busy,
    output logic              done
);
    localparam int WW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WW-1:0] LAST_IDX = WW'(DW - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        SET,
        DONE
    } state_t;

    state_t          state;
    logic [DW-1:0]   shreg;
    logic [DW-1:0]   rb_acc;
    logic [DW-1:0]   rb_next;
    logic [CNT_W-1:0] cnt;
    logic [WW-1:0]   widx;
    logic            kill;
    logic            last_bit;
    logic            last_idx;

    // Readback word with the current chain tail bit merged in.
    always_comb begin
        rb_next       = rb_acc;
        rb_next[widx] = shift_out;
    end

    assign kill     = abort && (state == FETCH || state == SHIFT || state == SET);
    assign last_bit = (cnt == LAST_BIT);
    assign last_idx = (widx == LAST_IDX);

    // Load sequencer; all outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            rb_acc        <= '0;
            cnt           <= '0;
            widx          <= '0;
            cen           <= 1'b0;
            set_in        <= 1'b0;
            shift_in      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.cfg_ready <= 1'b0;
            bus.rb_valid  <= 1'b0;
            bus.rb_data   <= '0;
        end else begin
            bus.rb_valid <= 1'b0;
            if (kill) begin
                // Abort wins over handshake and state advance.
                state         <= IDLE;
                cen           <= 1'b0;
                set_in        <= 1'b0;
                shift_in      <= 1'b0;
                busy          <= 1'b0;
                bus.cfg_ready <= 1'b0;
                rb_acc        <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state         <= FETCH;
                            busy          <= 1'b1;
                            bus.cfg_ready <= 1'b1;
                            cnt           <= '0;
                            widx          <= '0;
                            rb_acc        <= '0;
                        end
                    end
                    FETCH: begin
                        if (bus.cfg_valid) begin
                            state         <= SHIFT;
                            shreg         <= bus.cfg_data;
                            widx          <= '0;
                            bus.cfg_ready <= 1'b0;
                            cen           <= 1'b1;
                            shift_in      <= bus.cfg_data[0];
                        end
                    end
                    SHIFT: begin
                        shreg  <= shreg >> 1;
                        cnt    <= cnt + 1'b1;
                        rb_acc <= rb_next;
                        if (last_bit || last_idx) begin
                            bus.rb_valid <= 1'b1;
                            bus.rb_data  <= rb_next;
                            rb_acc       <= '0;
                        end
                        if (last_bit) begin
                            state    <= SET;
                            set_in   <= 1'b1;
                            shift_in <= 1'b0;
                        end else if (last_idx) begin
                            state         <= FETCH;
                            widx          <= '0;
                            cen           <= 1'b0;
                            shift_in      <= 1'b0;
                            bus.cfg_ready <= 1'b1;
                        end else begin
                            widx     <= widx + 1'b1;
                            shift_in <= shreg[1];
                        end
                    end
                    SET: begin
                        state  <= DONE;
                        cen    <= 1'b0;
                        set_in <= 1'b0;
                        done   <= 1'b1;
                    end
                    DONE: begin
                        state <= IDLE;
                        done  <= 1'b0;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cb_config_loader.sv
// Directed bench for cb_config_loader with a model chain
// and a second instance configured for a one-bit chain.
module tb_cb_config_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start = 1'b0;
    logic abort = 1'b0;
    logic shift_out;
    logic cen, set_in, shift_in, busy, done;

    logic start1 = 1'b0;
    logic abort1 = 1'b0;
    logic shift_out1;
    logic cen1, set_in1, shift_in1, busy1, done1;

    cb_config_loader_if #(.DW(16)) bus ();
    cb_config_loader_if #(.DW(16)) bus1 ();

    cb_config_loader #(.DW(16), .CHAIN_LEN(40), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .start(start), .abort(abort),
        .cen(cen), .set_in(set_in), .shift_in(shift_in),
        .shift_out(shift_out), .busy(busy), .done(done)
    );

    cb_config_loader #(.DW(16), .CHAIN_LEN(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .start(start1), .abort(abort1),
        .cen(cen1), .set_in(set_in1), .shift_in(shift_in1),
        .shift_out(shift_out1), .busy(busy1), .done(done1)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] words [3];
    localparam logic [39:0] EXP_CHAIN = 40'hFF_0F0F_A5C3;

    // Model of the 40-bit chain plus its shadow latch.
    logic [39:0] chain = '0;
    logic [39:0] shadow = '0;
    logic pre_ones = 1'b0;
    assign shift_out = chain[0];
    assign shift_out1 = 1'b1;

    int hs_cnt = 0, sh_cnt = 0, cen_cnt = 0, set_cnt = 0;
    int done_cnt = 0, rb_n = 0;
    logic [15:0] rb_log [64];

    // Event monitor for the main instance.
    always @(posedge clk) begin
        if (bus.cfg_valid && bus.cfg_ready) hs_cnt <= hs_cnt + 1;
        if (cen) cen_cnt <= cen_cnt + 1;
        if (cen && !set_in) sh_cnt <= sh_cnt + 1;
        if (cen && set_in) set_cnt <= set_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (bus.rb_valid) begin
            rb_log[rb_n[5:0]] <= bus.rb_data;
            rb_n <= rb_n + 1;
        end
        if (pre_ones) chain <= '1;
        else if (cen && !set_in) chain <= {shift_in, chain[39:1]};
        if (cen && set_in) shadow <= chain;
    end

    int hs1 = 0, sh1 = 0, cen1_cnt = 0, set1 = 0, done1_cnt = 0;
    int rb1_n = 0, sh1_ones = 0;
    logic [15:0] rb1_last = '0;

    // Event monitor for the one-bit-chain instance.
    always @(posedge clk) begin
        if (bus1.cfg_valid && bus1.cfg_ready) hs1 <= hs1 + 1;
        if (cen1) cen1_cnt <= cen1_cnt + 1;
        if (cen1 && !set_in1) sh1 <= sh1 + 1;
        if (cen1 && !set_in1 && shift_in1) sh1_ones <= sh1_ones + 1;
        if (cen1 && set_in1) set1 <= set1 + 1;
        if (done1) done1_cnt <= done1_cnt + 1;
        if (bus1.rb_valid) begin
            rb1_last <= bus1.rb_data;
            rb1_n <= rb1_n + 1;
        end
    end

    task automatic load3(input int stall, input bit mid_start,
                         output bit set_before_done,
                         output int stall_bad);
        int t;
        logic prev_set;
        int sh0;
        stall_bad = 0;
        prev_set = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data = words[i];
            t = 0;
            while (!bus.cfg_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                checks++;
                failures++;
                $display("FAIL load_ready_timeout word=%0d", i);
            end
            if (i == 1 && stall > 0) begin
                bus.cfg_valid = 1'b0;
                sh0 = sh_cnt;
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk);
                    if (cen !== 1'b0 || sh_cnt != sh0) stall_bad++;
                end
                bus.cfg_valid = 1'b1;
            end
            @(negedge clk);
            if (mid_start && i == 1) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        bus.cfg_valid = 1'b0;
        t = 0;
        while (!done && t < 300) begin
            prev_set = set_in;
            @(negedge clk);
            t++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL load_done_timeout got=%b want=1", done);
        end
        set_before_done = prev_set;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cen, set_in, shift_in, busy, done, bus.cfg_ready,
             bus.rb_valid, bus.rb_data} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0",
                     {cen, set_in, shift_in, busy, done,
                      bus.cfg_ready, bus.rb_valid, bus.rb_data});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int b_hs, b_sh, b_cen, b_set, b_done, b_rb;
        bit sbd;
        int sb;
        b_hs = hs_cnt; b_sh = sh_cnt; b_cen = cen_cnt;
        b_set = set_cnt; b_done = done_cnt; b_rb = rb_n;
        load3(0, 1'b0, sbd, sb);
        checks++;
        if (hs_cnt - b_hs != 3) begin
            failures++;
            $display("FAIL nom_handshakes got=%0d want=3", hs_cnt - b_hs);
        end
        checks++;
        if (sh_cnt - b_sh != 40 || cen_cnt - b_cen != 41) begin
            failures++;
            $display("FAIL nom_shift_cen got=%0d/%0d want=40/41",
                     sh_cnt - b_sh, cen_cnt - b_cen);
        end
        checks++;
        if (set_cnt - b_set != 1 || !sbd) begin
            failures++;
            $display("FAIL nom_set got=%0d prev=%b want=1/1",
                     set_cnt - b_set, sbd);
        end
        checks++;
        if (shadow !== EXP_CHAIN || chain !== EXP_CHAIN) begin
            failures++;
            $display("FAIL nom_chain got=%h want=%h", shadow, EXP_CHAIN);
        end
        checks++;
        if (rb_n - b_rb != 3 ||
            {rb_log[b_rb], rb_log[b_rb+1], rb_log[b_rb+2]} !== 48'h0) begin
            failures++;
            $display("FAIL nom_readback got=%0d words want=3 zero", rb_n - b_rb);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt - b_done != 1) begin
            failures++;
            $display("FAIL nom_done_end got=%b%b want=00", done, busy);
        end
    endtask

    task automatic test_readback();
        int b_rb;
        bit sbd;
        int sb;
        pre_ones = 1'b1;
        @(negedge clk);
        pre_ones = 1'b0;
        b_rb = rb_n;
        load3(0, 1'b0, sbd, sb);
        @(negedge clk);
        checks++;
        if (rb_n - b_rb != 3 ||
            {rb_log[b_rb], rb_log[b_rb+1], rb_log[b_rb+2]}
                !== 48'hFFFF_FFFF_00FF) begin
            failures++;
            $display("FAIL rb_ones got=%h%h%h want=ffffffff00ff",
                     rb_log[b_rb], rb_log[b_rb+1], rb_log[b_rb+2]);
        end
        b_rb = rb_n;
        load3(0, 1'b0, sbd, sb);
        @(negedge clk);
        checks++;
        if (rb_n - b_rb != 3 ||
            {rb_log[b_rb], rb_log[b_rb+1], rb_log[b_rb+2]}
                !== 48'hA5C3_0F0F_00FF) begin
            failures++;
            $display("FAIL rb_prev_load got=%h%h%h want=a5c30f0f00ff",
                     rb_log[b_rb], rb_log[b_rb+1], rb_log[b_rb+2]);
        end
        checks++;
        if (bus.rb_data !== 16'h00FF) begin
            failures++;
            $display("FAIL rb_hold got=%h want=00ff", bus.rb_data);
        end
    endtask

    task automatic test_stall();
        int b_hs;
        bit sbd;
        int sb;
        b_hs = hs_cnt;
        load3(5, 1'b0, sbd, sb);
        @(negedge clk);
        checks++;
        if (sb != 0) begin
            failures++;
            $display("FAIL stall_activity got=%0d want=0", sb);
        end
        checks++;
        if (shadow !== EXP_CHAIN || hs_cnt - b_hs != 3) begin
            failures++;
            $display("FAIL stall_chain got=%h want=%h", shadow, EXP_CHAIN);
        end
    endtask

    task automatic test_back_to_back();
        int b_hs, b_done;
        bit sbd;
        int sb;
        b_hs = hs_cnt;
        b_done = done_cnt;
        load3(0, 1'b1, sbd, sb);
        repeat (3) @(negedge clk);
        checks++;
        if (hs_cnt - b_hs != 3 || done_cnt - b_done != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start got=%0d/%0d/%b want=3/1/0",
                     hs_cnt - b_hs, done_cnt - b_done, busy);
        end
    endtask

    task automatic test_abort();
        int b_sh, b_set, b_done, b_rb, t;
        b_sh = sh_cnt; b_set = set_cnt;
        b_done = done_cnt; b_rb = rb_n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_data = words[0];
        @(negedge clk);
        bus.cfg_data = words[1];
        t = 0;
        while (!(cen && sh_cnt - b_sh == 19) && t < 200) begin
            @(negedge clk);
            t++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bus.cfg_valid = 1'b0;
        checks++;
        if ({cen, busy, bus.cfg_ready} !== 3'b000) begin
            failures++;
            $display("FAIL abort_outputs got=%b want=000",
                     {cen, busy, bus.cfg_ready});
        end
        repeat (5) @(negedge clk);
        checks++;
        if (sh_cnt - b_sh != 20 || set_cnt != b_set || done_cnt != b_done) begin
            failures++;
            $display("FAIL abort_no_set got=%0d/%0d/%0d want=20/0/0",
                     sh_cnt - b_sh, set_cnt - b_set, done_cnt - b_done);
        end
        checks++;
        if (rb_n - b_rb != 1) begin
            failures++;
            $display("FAIL abort_rb got=%0d want=1", rb_n - b_rb);
        end
    endtask

    task automatic test_async_reset();
        int b_sh, b_done, t;
        bit sbd;
        int sb;
        b_sh = sh_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_data = words[0];
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        t = 0;
        while (sh_cnt - b_sh < 5 && t < 100) begin
            @(negedge clk);
            t++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cen, set_in, shift_in, busy, done, bus.cfg_ready,
             bus.rb_valid, bus.rb_data} !== 23'd0) begin
            failures++;
            $display("FAIL async_rst got=%b want=0",
                     {cen, set_in, shift_in, busy, done,
                      bus.cfg_ready, bus.rb_valid, bus.rb_data});
        end
        #1 rst = 1'b0;
        @(negedge clk);
        b_done = done_cnt;
        load3(0, 1'b0, sbd, sb);
        @(negedge clk);
        checks++;
        if (shadow !== EXP_CHAIN || done_cnt - b_done != 1) begin
            failures++;
            $display("FAIL async_reload got=%h want=%h", shadow, EXP_CHAIN);
        end
    endtask

    task automatic test_chain1();
        int t;
        bus1.cfg_valid = 1'b1;
        bus1.cfg_data = 16'h0001;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        t = 0;
        while (!done1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        bus1.cfg_valid = 1'b0;
        checks++;
        if (hs1 != 1 || sh1 != 1 || set1 != 1 || cen1_cnt != 2) begin
            failures++;
            $display("FAIL len1_counts got=%0d/%0d/%0d/%0d want=1/1/1/2",
                     hs1, sh1, set1, cen1_cnt);
        end
        checks++;
        if (done1_cnt != 1 || sh1_ones != 1) begin
            failures++;
            $display("FAIL len1_done got=%0d/%0d want=1/1", done1_cnt, sh1_ones);
        end
        checks++;
        if (rb1_n != 1 || rb1_last !== 16'h0001) begin
            failures++;
            $display("FAIL len1_rb got=%0d/%h want=1/0001", rb1_n, rb1_last);
        end
    endtask

    initial begin
        words[0] = 16'hA5C3;
        words[1] = 16'h0F0F;
        words[2] = 16'h00FF;
        bus.cfg_valid = 1'b0;
        bus.cfg_data = '0;
        bus1.cfg_valid = 1'b0;
        bus1.cfg_data = '0;
        test_reset();
        test_nominal();
        test_readback();
        test_stall();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_chain1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cb_config_loader.md
Name: cb_config_loader

Overview:
Sequencer that loads a connection block's configuration shift chain from a word-wide host stream. Sits between the tile-level configuration bus and the connection block's `cen` / `set_in` / `shift_in` / `shift_out` chain pins. It serialises words LSB-first, issues the final set pulse, and returns the bits shifted out of the chain as readback words.

Parameters:
- DW, 16, width of host configuration and readback words.
- CHAIN_LEN, 40, number of bits in the target configuration chain (must be ≥1).
- CNT_W, 16, width of the chain bit counter (must satisfy 2^CNT_W > CHAIN_LEN).

Ports:
- clk  input  1  fabric clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- abort  input  1  cancels a load in progress.
- cfg_valid  input  1  host word valid.
- cfg_ready  output  1  loader can accept a word.
- cfg_data  input  DW  host word; bit 0 is shifted first.
- cen  output  1  chain enable to the connection block.
- set_in  output  1  chain set/latch strobe.
- shift_in  output  1  serial data to the chain.
- shift_out  input  1  serial data from the chain tail.
- rb_valid  output  1  readback word valid (one-cycle pulse, no backpressure).
- rb_data  output  DW  readback word.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after a successful set.

Behaviour:
- Chain semantics:
  - Chain shifts one bit on a clk edge with cen=1 and set_in=0.
  - Chain latches its shadow register on a clk edge with cen=1 and set_in=1.
  - cen=0 holds the chain.
- Reset values: every output is 0, FSM is in IDLE, counters are cleared, and the readback register is cleared.
- States: IDLE, FETCH, SHIFT, SET, DONE.
- IDLE:
  - cfg_ready=0, cen=0.
  - On start=1, clear the bit counter and readback index, then go to FETCH.
- FETCH:
  - cfg_ready=1, cen=0.
  - On cfg_valid&&cfg_ready, capture cfg_data into the shift register, clear the word bit index, and go to SHIFT on the next cycle.
  - cfg_valid=0 stalls in FETCH indefinitely.
- SHIFT:
  - Each cycle: cen=1, set_in=0, shift_in = shreg[0]; the shift register shifts right; bit counter and word index increment.
  - One chain bit per cycle, with no gaps inside a word.
  - After the bit with counter value CHAIN_LEN-1, go to SET.
  - Otherwise, when word index reaches DW-1, go to FETCH.
  - Unused upper bits of the final partial word are discarded and never shifted.
- SET:
  - Lasts exactly one cycle with cen=1, set_in=1, shift_in=0, then go to DONE.
- DONE:
  - One cycle with done=1, busy=1, then go to IDLE.
- Word count: ceil(CHAIN_LEN/DW) host words are accepted per load. Total cen-high cycles = CHAIN_LEN + 1.
- Readback:
  - On every SHIFT cycle, sample shift_out into rb bit position (readback index mod DW).
  - rb_valid pulses for one cycle on the cycle after DW bits have been collected, or after the final chain bit.
  - In a partial final word, the unfilled upper bits of rb_data are 0.
  - rb_data holds its value until the next readback word completes.
  - Readback of load N therefore returns the chain contents from before load N.
- Abort:
  - abort=1 in FETCH, SHIFT or SET goes to IDLE on the next edge.
  - No set pulse is issued after an abort edge, and done is not pulsed.
  - cen drops to 0 in the following cycle.
  - Any partial readback word is dropped.
  - abort has priority over cfg handshake and state advance in the same cycle.
  - abort in IDLE or DONE has no effect.
- start while busy=1 is ignored.
- start and abort asserted together in IDLE: start wins.
- Asynchronous rst mid-load: immediate IDLE with all outputs 0. The chain is left partially shifted with no set issued.

Test Plan:
1. Nominal load, CHAIN_LEN=40, DW=16. start, then words 0xA5C3, 0x0F0F, 0x00FF with cfg_valid held high → 3 handshakes; 40 SHIFT cycles with shift_in sequence = LSB-first concatenation (only the low 8 bits of 0x00FF shifted); one SET cycle; done on the cycle after set_in. A model chain must hold those 40 bits.
2. Readback. Preload the model chain with all-ones, then run the load from test 1 → rb_valid pulses three times with rb_data = 0xFFFF, 0xFFFF, 0x00FF. A second load returns the bits from the first load.
3. Host stall. cfg_valid low for 5 cycles between words 1 and 2 → cen=0 and no shifting during the stall; the final chain contents are identical to test 1.
4. Abort. Assert abort on the 20th SHIFT cycle → cen=0 within one cycle; set_in never asserted; done=0; busy=0 after the abort edge; no rb_valid for the partial word.
5. Async reset mid-SHIFT. Pulse rst between clk edges → all outputs 0 immediately. A fresh start then completes a full load normally.
6. Edge cases:
   - start while busy → ignored; word count still 3.
   - CHAIN_LEN=1 → exactly 1 word accepted, 1 shift cycle, 1 set cycle.
